// File: rtl/dec_scan_pkg.sv
// Shared types, constants and helpers for the decoder scan sequencer.
package dec_scan_pkg;

    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDwell
    } scan_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_DIG-1:0] mask);
        lowest_set = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set = i[IDX_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/dec_scan_ctrl_if.sv
// Control/config inputs and decoder-facing outputs of the scan sequencer.
interface dec_scan_ctrl_if
    import dec_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned BLANK_W = 4
);

    logic               start;
    logic               stop;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank_cycles;
    logic [NUM_DIG-1:0] digit_mask;

    logic               sel_a;
    logic               sel_b;
    logic               sel_en;
    logic               busy;
    logic               phase_done;
    logic               scan_wrap;

    modport master (
        output start, stop, dwell, blank_cycles, digit_mask,
        input  sel_a, sel_b, sel_en, busy, phase_done, scan_wrap
    );

    modport slave (
        input  start, stop, dwell, blank_cycles, digit_mask,
        output sel_a, sel_b, sel_en, busy, phase_done, scan_wrap
    );

endinterface

// File: rtl/scan_next_idx.sv
// Circular search for the next enabled digit after cur_idx.
module scan_next_idx
    import dec_scan_pkg::*;
(
    input  logic [NUM_DIG-1:0] mask,
    input  logic [IDX_W-1:0]   cur_idx,
    output logic [IDX_W-1:0]   nxt_idx,
    output logic               any,
    output logic               wrap
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from far to near so the nearest set bit wins; offset 4 is cur_idx itself.
    always_comb begin
        nxt_idx = cur_idx;
        any     = 1'b0;
        cand    = '0;
        for (int k = NUM_DIG; k >= 1; k--) begin
            cand = cur_idx + k[IDX_W-1:0];
            if (mask[cand]) begin
                nxt_idx = cand;
                any     = 1'b1;
            end
        end
    end

    assign wrap = any && (nxt_idx <= cur_idx);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer driving the A/B/Enable inputs of a 2-to-4 decoder.
module dec_scan_ctrl
    import dec_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned BLANK_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    dec_scan_ctrl_if.slave  scan_if
);

    localparam int unsigned CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   nxt_idx_q;
    logic               nxt_any_q;

    logic sel_a_q, sel_b_q, sel_en_q, busy_q, phase_done_q, scan_wrap_q;

    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_any;
    logic               nxt_wrap;
    logic               last_d;
    logic               launch_blank;
    logic [CNT_W-1:0]   launch_cnt;
    scan_state_e        launch_state;

    // Dwell of 0 behaves as 1, so the down-counter load never underflows.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        dwell_load = (d == '0) ? '0 : CNT_W'(d - DWELL_W'(1));
    endfunction

    function automatic logic [CNT_W-1:0] blank_load(input logic [BLANK_W-1:0] b);
        blank_load = (b == '0) ? '0 : CNT_W'(b - BLANK_W'(1));
    endfunction

    // Entry into a new digit: optional blank gap, then dwell.
    assign launch_blank = (scan_if.blank_cycles != '0);
    assign launch_state = launch_blank ? StBlank : StDwell;
    assign launch_cnt   = launch_blank ? blank_load(scan_if.blank_cycles)
                                       : dwell_load(scan_if.dwell);

    // Next-state logic for state, index, counter and latched dwell.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        unique case (state_q)
            StIdle: begin
                if (scan_if.start && !scan_if.stop && (scan_if.digit_mask != '0)) begin
                    idx_d   = lowest_set(scan_if.digit_mask);
                    dwell_d = scan_if.dwell;
                    state_d = launch_state;
                    cnt_d   = launch_cnt;
                end
            end
            StBlank: begin
                if (scan_if.stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StDwell;
                    cnt_d   = dwell_load(dwell_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDwell: begin
                if (scan_if.stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (!nxt_any_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = nxt_idx_q;
                        dwell_d = scan_if.dwell;
                        state_d = launch_state;
                        cnt_d   = launch_cnt;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The upcoming digit is looked up from the mask seen as the last dwell cycle begins,
    // so scan_wrap can be a register and still agree with the actual advance.
    scan_next_idx u_next_idx (
        .mask    (scan_if.digit_mask),
        .cur_idx (idx_d),
        .nxt_idx (nxt_idx),
        .any     (nxt_any),
        .wrap    (nxt_wrap)
    );

    assign last_d = (state_d == StDwell) && (cnt_d == '0);

    // State registers plus registered decoder-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            dwell_q      <= '0;
            nxt_idx_q    <= '0;
            nxt_any_q    <= 1'b0;
            sel_a_q      <= 1'b0;
            sel_b_q      <= 1'b0;
            sel_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            phase_done_q <= 1'b0;
            scan_wrap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            if (last_d) begin
                nxt_idx_q <= nxt_idx;
                nxt_any_q <= nxt_any;
            end
            sel_a_q      <= idx_d[1];
            sel_b_q      <= idx_d[0];
            sel_en_q     <= (state_d == StDwell);
            busy_q       <= (state_d != StIdle);
            phase_done_q <= last_d;
            scan_wrap_q  <= last_d && nxt_wrap;
        end
    end

    assign scan_if.sel_a      = sel_a_q;
    assign scan_if.sel_b      = sel_b_q;
    assign scan_if.sel_en     = sel_en_q;
    assign scan_if.busy       = busy_q;
    assign scan_if.phase_done = phase_done_q;
    assign scan_if.scan_wrap  = scan_wrap_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected digit phases, a monitor checks each phase_done.
module tb_dec_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dec_scan_ctrl_if #(.DWELL_W(16), .BLANK_W(4)) bus ();

    dec_scan_ctrl #(.DWELL_W(16), .BLANK_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_if (bus)
    );

    typedef struct {
        logic [1:0] idx;
        logic       wrap;
        int         dw;
        int         gap;
    } phase_t;

    phase_t      exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference rules: lowest enabled digit, then circular search from the next one.
    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_set(input logic [3:0] m, input int cur);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.busy, bus.sel_en, bus.sel_a, bus.sel_b, bus.phase_done, bus.scan_wrap};
    endfunction

    // Monitor: measure each dwell run and the blank gap before it, compare on phase_done.
    int         run_len = 0;
    int         gap_cnt = 0;
    int         cur_gap = 0;
    bit         in_run = 0;
    logic [1:0] run_idx = '0;

    initial begin
        phase_t e;
        logic [1:0] cur;
        forever begin
            @(negedge clk);
            cur = {bus.sel_a, bus.sel_b};
            if (!rst_n || !bus.busy) begin
                run_len = 0;
                gap_cnt = 0;
                in_run  = 0;
            end else if (bus.sel_en) begin
                if (!in_run || cur != run_idx) begin
                    cur_gap = gap_cnt;
                    run_len = 1;
                    run_idx = cur;
                    in_run  = 1;
                    gap_cnt = 0;
                end else begin
                    run_len++;
                end
            end else begin
                in_run = 0;
                gap_cnt++;
            end
            if (bus.phase_done) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_phase_done: got idx=%0d wrap=%0b, want none",
                             cur, bus.scan_wrap);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.idx || bus.scan_wrap !== e.wrap || run_len != e.dw ||
                        cur_gap != e.gap) begin
                        n_err++;
                        $display("FAIL phase: got idx=%0d wrap=%0b dwell=%0d gap=%0d, want idx=%0d wrap=%0b dwell=%0d gap=%0d",
                                 cur, bus.scan_wrap, run_len, cur_gap, e.idx, e.wrap, e.dw, e.gap);
                    end
                end
                in_run  = 0;
                gap_cnt = 0;
            end else if (bus.scan_wrap) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_scan_wrap: got 1 want 0");
            end
        end
    end

    // Run p digit phases with fixed config, then stop during the last cycle of phase p.
    task automatic run_scan(input logic [3:0] m, input int dw, input int bl, input int p);
        phase_t e;
        int idx, nxt, eff, len;
        eff = (dw == 0) ? 1 : dw;
        idx = lowest(m);
        for (int i = 0; i < p; i++) begin
            nxt    = next_set(m, idx);
            e.idx  = idx[1:0];
            e.wrap = (nxt <= idx);
            e.dw   = eff;
            e.gap  = bl;
            exp_q.push_back(e);
            idx = nxt;
        end
        len = p * (bl + eff);
        @(negedge clk);
        bus.digit_mask   = m;
        bus.dwell        = dw[15:0];
        bus.blank_cycles = bl[3:0];
        bus.start        = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (len - 1) @(posedge clk);
        #1 bus.stop = 1'b1;
        @(posedge clk);
        #1 bus.stop = 1'b0;
        @(negedge clk);
        check("stop_to_idle", {30'd0, bus.busy, bus.sel_en}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        phase_t e;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.dwell        = '0;
        bus.blank_cycles = '0;
        bus.digit_mask   = '0;

        repeat (3) @(negedge clk);
        check("in_reset", {26'd0, outs()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", {26'd0, outs()}, 32'd0);

        // Directed: full scan, sparse back-to-back, single digit with zero dwell.
        run_scan(4'b1111, 3, 1, 5);
        run_scan(4'b1010, 2, 0, 6);
        run_scan(4'b0100, 0, 0, 4);

        // Stop on cycle 2 of a 5-cycle dwell: idle next cycle, idx held, no phase_done.
        @(negedge clk);
        bus.digit_mask = 4'b1000; bus.dwell = 16'd5; bus.blank_cycles = 4'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("stop_latency_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1 bus.stop = 1'b1;
        @(posedge clk);
        #1 bus.stop = 1'b0;
        @(negedge clk);
        check("stop_mid_dwell", {26'd0, outs()}, 32'b001100);
        bus.digit_mask = 4'b0000;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        check("start_empty_mask", {30'd0, bus.busy, bus.sel_en}, 32'd0);
        bus.start = 1'b0;

        // Start and stop together in IDLE: stop wins.
        bus.digit_mask = 4'b0011; bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_same", {30'd0, bus.busy, bus.sel_en}, 32'd0);

        // Mask drops to 0 mid-dwell: one phase_done without wrap, then idle with idx held.
        e.idx = 2'd1; e.wrap = 1'b0; e.dw = 5; e.gap = 0;
        exp_q.push_back(e);
        @(negedge clk);
        bus.digit_mask = 4'b0110; bus.dwell = 16'd5; bus.blank_cycles = 4'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("start_latency_en", {30'd0, bus.busy, bus.sel_en}, 32'd3);
        @(posedge clk);
        #1 bus.digit_mask = 4'b0000;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mask_zero_idle", {28'd0, bus.busy, bus.sel_en, bus.sel_a, bus.sel_b}, 32'b0001);
        check("mask_zero_drained", exp_q.size(), 32'd0);

        // Asynchronous reset while blanking.
        @(negedge clk);
        bus.digit_mask = 4'b1100; bus.dwell = 16'd3; bus.blank_cycles = 4'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("blank_state", {28'd0, bus.busy, bus.sel_en, bus.sel_a, bus.sel_b}, 32'b1010);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {26'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_auto_restart", {26'd0, outs()}, 32'd0);
        end

        // Randomized scans.
        for (int r = 0; r < 12; r++) begin
            run_scan(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 6)));
        end

        // Longest dwell must not overflow the counter.
        run_scan(4'b0001, 65535, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dec_scan_ctrl.md
Name: dec_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 2-to-4 decoder (dec2x4) and drives its A, B and Enable inputs. It steps a 2-bit select index through the digits enabled in a 4-bit mask. Each enabled digit is held for a programmable dwell time, and a programmable blanking gap (Enable low) separates consecutive digits. Typical use is digit/row scanning of a 4-way multiplexed display or bus.

Parameters:
DWELL_W, 16, width of dwell count input
BLANK_W, 4, width of blanking count input

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; begins scanning when sampled high in IDLE
stop  input  1  pulse; aborts scanning, returns to IDLE
dwell  input  DWELL_W  cycles Enable stays high per digit (0 treated as 1)
blank_cycles  input  BLANK_W  cycles Enable stays low before each digit (0 = no gap)
digit_mask  input  4  bit i = 1 enables digit i
sel_a  output  1  to decoder A = idx[1]
sel_b  output  1  to decoder B = idx[0]
sel_en  output  1  to decoder Enable
busy  output  1  high in any state other than IDLE
phase_done  output  1  one-cycle pulse on the last dwell cycle of each digit
scan_wrap  output  1  one-cycle pulse, coincident with phase_done, when the next digit index is less than or equal to the current one

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE, idx = 0, sel_a = 0, sel_b = 0, sel_en = 0, busy = 0, phase_done = 0, scan_wrap = 0, counters = 0. Reset asserted mid-scan forces these values immediately, without waiting for a clock edge.
- Registered outputs: all outputs are registered and derive from state/idx/counter registers only. There is no combinational path from any input to any output.
- States: IDLE, BLANK, DWELL.
- IDLE:
  - sel_en = 0.
  - start = 1 and stop = 0 and digit_mask != 0: on the next edge, idx = lowest set bit of digit_mask and blank_cycles/dwell are latched.
  - If latched blank = 0, go to DWELL; otherwise go to BLANK.
  - start with digit_mask = 0 is ignored and the block stays in IDLE.
- BLANK:
  - sel_en = 0, sel_a/sel_b already show the new idx.
  - Stays exactly latched-blank cycles, then goes to DWELL.
- DWELL:
  - sel_en = 1 for exactly max(latched dwell, 1) cycles.
  - On the last cycle, phase_done = 1.
  - Next idx = first set bit of the current digit_mask searching circularly from idx+1 (3 wraps to 0). A mask with a single set bit selects the same idx again.
  - scan_wrap = 1 on that cycle if next idx <= idx.
  - dwell and blank_cycles are re-latched, then the block goes to BLANK, or to DWELL if blank = 0. Back-to-back DWELL keeps sel_en high with only the select bits changing.
- Config sampling: digit_mask is sampled only at start and at each digit advance. dwell/blank_cycles changes mid-phase take effect at the next digit.
- Mask becomes 0 at an advance: phase_done still pulses, scan_wrap = 0, next state is IDLE with idx unchanged.
- stop: when sampled high in BLANK or DWELL, the next edge gives IDLE with sel_en = 0. phase_done and scan_wrap are not asserted on that cycle, and idx is held.
- start and stop both high in the same cycle: stop wins.
- start while busy is ignored.
- Latency: start sampled at edge t gives busy = 1 and the first select value at t+1. With blank = 0, sel_en also rises at t+1.
- Counters: down-counters loaded with N-1 and terminal at 0. The maximum dwell of 2^DWELL_W-1 cycles must not overflow.

Decomposition:
- Package dec_scan_pkg holds:
  - the state enum typedef (IDLE, BLANK, DWELL);
  - the constants NUM_DIG = 4 and IDX_W = 2;
  - a function lowest_set(mask).
- One sub-module, scan_next_idx, is natural. It is purely combinational with inputs mask[3:0] and cur_idx[1:0], and outputs nxt_idx[1:0], any and wrap.

Test Plan:
- Full scan: mask=4'b1111, dwell=3, blank=1, start pulse → sel_en high for 3 cycles per digit, 1-cycle gaps between digits, {a,b} sequence 00, 01, 10, 11, 00. scan_wrap pulses once per 4 digits; the decoder output Z one-hots in order.
- Sparse mask with no blank: mask=4'b1010, dwell=2, blank=0 → idx alternates 01, 11. sel_en stays continuously high. scan_wrap is asserted on each 11→01 advance.
- Single digit and zero dwell: mask=4'b0100, dwell=0 → idx stays at 10 and dwell behaves as 1 cycle. Every phase_done coincides with scan_wrap.
- stop mid-DWELL: on cycle 2 of dwell=5, stop=1 → next cycle gives sel_en=0 and busy=0 with no phase_done. start=1 with mask=0 is then ignored.
- Async reset mid-BLANK: drop rst_n between clock edges → all outputs 0 immediately. After release, start is required before any activity.
- Simultaneous events: start and stop high together in IDLE → stays in IDLE. Mask changed to 0 during DWELL → one phase_done, then IDLE.
